// File: rtl/register.sv
// rtl/register.sv - WIDTH-bit data register, rising-edge capture, async active-low reset.
// Optional feature: define REGISTER_VALID_EN to add the flop-driven regValid output.
module register #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] regIn,
  output logic [WIDTH-1:0] regOut
`ifdef REGISTER_VALID_EN
  ,
  output logic             regValid
`endif
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  assign data_d = regIn;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign regOut = data_q;

`ifdef REGISTER_VALID_EN
  // Sticky: first edge after reset release marks regOut as holding real data.
  logic valid_q;
  logic valid_d;

  assign valid_d = 1'b1;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign regValid = valid_q;
`endif

endmodule

// File: tb/tb_register.sv
// tb/tb_register.sv - directed self-checking bench for register (WIDTH=32, RESET_VALUE=0).
// Define REGISTER_VALID_EN on both bench and RTL to also exercise regValid.
module tb_register;

  logic        Clk;
  logic        reset;
  logic [31:0] regIn;
  logic [31:0] regOut;
`ifdef REGISTER_VALID_EN
  logic        regValid;
`endif

  int n_cmp;
  int n_bad;

  register #(
    .WIDTH       (32),
    .RESET_VALUE (32'h0000_0000)
  ) dut (
    .Clk    (Clk),
    .reset  (reset),
    .regIn  (regIn),
    .regOut (regOut)
`ifdef REGISTER_VALID_EN
    ,
    .regValid (regValid)
`endif
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] stream [3];
  logic [31:0] pats   [4];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    stream[0] = 32'hFFAA_FF22;
    stream[1] = 32'hBB44_FF22;
    stream[2] = 32'h1623_FF22;
    pats[0]   = 32'h0000_0001;
    pats[1]   = 32'h8000_0000;
    pats[2]   = 32'hA5A5_A5A5;
    pats[3]   = 32'h5A5A_5A5A;

    reset = 1'b0;
    regIn = 32'h0000_0000;
    #1;
    check("reset_state", regOut, 32'h0000_0000);
`ifdef REGISTER_VALID_EN
    check("valid_in_reset", {31'd0, regValid}, 32'd0);
`endif
    repeat (2) @(posedge Clk);

    // Release mid-cycle, then one capture to get regOut to all ones.
    @(negedge Clk);
    reset = 1'b1;
    regIn = 32'hFFFF_FFFF;
    #1;
    check("pre_first_edge", regOut, 32'h0000_0000);
`ifdef REGISTER_VALID_EN
    check("valid_before_edge", {31'd0, regValid}, 32'd0);
`endif
    @(posedge Clk); #1;
    check("first_capture", regOut, 32'hFFFF_FFFF);
`ifdef REGISTER_VALID_EN
    check("valid_after_edge", {31'd0, regValid}, 32'd1);
`endif

    // Asynchronous assertion between edges.
    @(negedge Clk);
    reset = 1'b0;
    #1;
    check("async_reset", regOut, 32'h0000_0000);
`ifdef REGISTER_VALID_EN
    check("valid_async_clear", {31'd0, regValid}, 32'd0);
`endif

    // Reset held across 3 edges with all-ones input.
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      check($sformatf("reset_hold_%0d", i), regOut, 32'h0000_0000);
    end

    // Release: no change until the next rising edge.
    @(negedge Clk);
    reset = 1'b1;
    regIn = 32'hFFFF_FF22;
    #5;
    check("release_wait", regOut, 32'h0000_0000);
    @(posedge Clk); #1;
    check("release_capture", regOut, 32'hFFFF_FF22);

    // Streaming: each value shows up one edge later, in order.
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      regIn = stream[i];
      #1;
      check($sformatf("stream_hold_%0d", i), regOut, (i == 0) ? 32'hFFFF_FF22 : stream[i-1]);
      @(posedge Clk); #1;
      check($sformatf("stream_cap_%0d", i), regOut, stream[i]);
    end

    // Input toggling between edges must not reach regOut.
    @(negedge Clk);
    regIn = 32'h1234_5678;
    #2;
    regIn = 32'h9ABC_DEF0;
    #1;
    check("between_edge_a", regOut, 32'h1623_FF22);
    #2;
    regIn = 32'h1234_5678;
    #1;
    check("between_edge_b", regOut, 32'h1623_FF22);
    @(posedge Clk); #1;
    check("between_edge_cap", regOut, 32'h1234_5678);

    // Unchanged input on consecutive edges.
    @(posedge Clk); #1;
    check("repeat_same", regOut, 32'h1234_5678);

    // Bit-exact capture of single-bit and alternating patterns.
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      regIn = pats[i];
      @(posedge Clk); #1;
      check($sformatf("pattern_%0d", i), regOut, pats[i]);
    end

    // Mid-run reset pulse, then recovery.
    @(negedge Clk);
    reset = 1'b0;
    #1;
    check("pulse_reset", regOut, 32'h0000_0000);
`ifdef REGISTER_VALID_EN
    check("pulse_valid", {31'd0, regValid}, 32'd0);
`endif
    #3;
    reset = 1'b1;
    regIn = 32'hC0DE_0042;
    @(posedge Clk); #1;
    check("pulse_recover", regOut, 32'hC0DE_0042);
`ifdef REGISTER_VALID_EN
    check("pulse_valid_set", {31'd0, regValid}, 32'd1);
    @(posedge Clk); #1;
    check("valid_sticky", {31'd0, regValid}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
